// File: rtl/line_feeder.sv
// ---------------------------------------------------------------------------
// line_feeder
//   Streams one frame (W x H cells) from a frame memory into a 3-row line
//   buffer and reports which cell currently sits in the buffer's middle tap.
//
//   A pass pushes T = W*H + 2W - 1 words. Indices 0..N-1 are read from frame
//   memory. Indices N..T-1 flush the buffer so the last row reaches the
//   middle tap.
//
//   Optional feature, selected by the macro LINE_FEEDER_WRAP_EN:
//     defined   - flush indices re-read memory rows 0-1 (periodic y boundary)
//     undefined - flush indices push zero words without a memory read
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous active-high reset
//   start        : one-cycle pulse, begins a pass (ignored unless idle)
//   hold         : stalls issuing of new indices
//   mem_rd       : frame memory read strobe
//   mem_addr     : frame memory read address
//   mem_rdata    : read data, valid one cycle after mem_rd
//   sr_d         : word pushed into the line buffer
//   sr_en        : active-low push strobe
//   center_valid : middle tap holds cell (center_x, center_y)
//   center_x/y   : coordinates of the middle-tap cell
//   busy         : pass in progress
//   done         : one-cycle pulse with the final center_valid
// ---------------------------------------------------------------------------
module line_feeder #(
    parameter int SCREEN_WIDTH  = 8,
    parameter int SCREEN_HEIGHT = 8,
    parameter int N_BITS        = 15,
    parameter int ADDR_BITS     = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             hold,
    output logic                             mem_rd,
    output logic [ADDR_BITS-1:0]             mem_addr,
    input  logic [N_BITS-1:0]                mem_rdata,
    output logic [N_BITS-1:0]                sr_d,
    output logic                             sr_en,
    output logic                             center_valid,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  center_x,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] center_y,
    output logic                             busy,
    output logic                             done
);

    localparam int W  = SCREEN_WIDTH;
    localparam int H  = SCREEN_HEIGHT;
    localparam int N  = W * H;
    localparam int T  = N + 2 * W - 1;
    localparam int IB = $clog2(T + 1);
    localparam int XB = $clog2(W);
    localparam int YB = $clog2(H);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic [IB-1:0]   r_idx;        // next index to issue
    logic [IB-1:0]   r_pcnt;       // pushes completed so far
    logic            r_push;       // a push happens this cycle
    logic            r_push_mem;   // this cycle's push word comes from memory
    logic            r_cv;
    logic            r_done;
    logic [XB-1:0]   r_cx;
    logic [YB-1:0]   r_cy;

    logic            w_issue;
    logic            w_rd_mem;
    logic [IB-1:0]   w_idx_nxt;
    logic [IB-1:0]   w_addr_full;

    assign w_idx_nxt = r_idx + IB'(1);

    // Index issue qualifier and memory-read decision for the current cycle.
    always_comb begin
        w_issue  = 1'b0;
        w_rd_mem = 1'b0;
        if ((r_state == S_FILL) || (r_state == S_STREAM) || (r_state == S_FLUSH)) begin
            w_issue = ~hold;
        end else begin
            w_issue = 1'b0;
        end
`ifdef LINE_FEEDER_WRAP_EN
        w_rd_mem = w_issue;
`else
        if (r_state == S_FLUSH) begin
            w_rd_mem = 1'b0;
        end else begin
            w_rd_mem = w_issue;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; phase changes happen on the issue that crosses a boundary.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_FILL;
                else       w_next_state = S_IDLE;
            end
            S_FILL: begin
                if (w_issue && (w_idx_nxt == IB'(2 * W))) w_next_state = S_STREAM;
                else                                       w_next_state = S_FILL;
            end
            S_STREAM: begin
                if (w_issue && (w_idx_nxt == IB'(N))) w_next_state = S_FLUSH;
                else                                   w_next_state = S_STREAM;
            end
            S_FLUSH: begin
                if (w_issue && (w_idx_nxt == IB'(T))) w_next_state = S_DRAIN;
                else                                   w_next_state = S_FLUSH;
            end
            S_DRAIN: begin
                // r_done marks the final center cycle; leave after it.
                if (r_done) w_next_state = S_IDLE;
                else        w_next_state = S_DRAIN;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        w_addr_full = r_idx;
        if (r_state == S_FLUSH) begin
            // Flush indices wrap back onto rows 0-1 of the frame.
            w_addr_full = r_idx - IB'(N);
        end else begin
            w_addr_full = r_idx;
        end
        mem_rd       = w_rd_mem;
        mem_addr     = w_rd_mem ? ADDR_BITS'(w_addr_full) : {ADDR_BITS{1'b0}};
        sr_en        = ~r_push;
        sr_d         = (r_push && r_push_mem) ? mem_rdata : {N_BITS{1'b0}};
        busy         = (r_state != S_IDLE);
        center_valid = r_cv;
        done         = r_done;
        center_x     = r_cx;
        center_y     = r_cy;
    end

    // Issue index counter, restarted by an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= {IB{1'b0}};
        end else if ((r_state == S_IDLE) && start) begin
            r_idx <= {IB{1'b0}};
        end else if (w_issue) begin
            r_idx <= w_idx_nxt;
        end else begin
            r_idx <= r_idx;
        end
    end

    // Push pipeline: an issue becomes a push one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_push     <= 1'b0;
            r_push_mem <= 1'b0;
            r_pcnt     <= {IB{1'b0}};
        end else begin
            r_push     <= w_issue;
            r_push_mem <= w_rd_mem;
            if ((r_state == S_IDLE) && start) begin
                r_pcnt <= {IB{1'b0}};
            end else if (r_push) begin
                r_pcnt <= r_pcnt + IB'(1);
            end else begin
                r_pcnt <= r_pcnt;
            end
        end
    end

    // Middle-tap tracking: push count k >= 2W makes cell k-2W visible next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cv   <= 1'b0;
            r_done <= 1'b0;
            r_cx   <= {XB{1'b0}};
            r_cy   <= {YB{1'b0}};
        end else begin
            r_cv   <= r_push && (r_pcnt >= IB'(2 * W - 1));
            r_done <= r_push && (r_pcnt == IB'(T - 1));
            if (r_push && (r_pcnt == IB'(2 * W - 1))) begin
                r_cx <= {XB{1'b0}};
                r_cy <= {YB{1'b0}};
            end else if (r_push && (r_pcnt > IB'(2 * W - 1))) begin
                if (r_cx == XB'(W - 1)) begin
                    r_cx <= {XB{1'b0}};
                    r_cy <= r_cy + YB'(1);
                end else begin
                    r_cx <= r_cx + XB'(1);
                    r_cy <= r_cy;
                end
            end else begin
                r_cx <= r_cx;
                r_cy <= r_cy;
            end
        end
    end

endmodule

// File: tb/tb_line_feeder.sv
// ---------------------------------------------------------------------------
// tb_line_feeder
//   Self-checking bench for line_feeder (W=8, H=8). A reference model tracks
//   the pass in terms of issued indices, expected push words and center
//   coordinates (computed by division/modulo), and compares every cycle.
// ---------------------------------------------------------------------------
module tb_line_feeder;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NB = 15;
    localparam int AB = 6;
    localparam int N  = W * H;
    localparam int T  = N + 2 * W - 1;
`ifdef LINE_FEEDER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          hold;
    logic          mem_rd;
    logic [AB-1:0] mem_addr;
    logic [NB-1:0] mem_rdata = '0;
    logic [NB-1:0] sr_d;
    logic          sr_en;
    logic          center_valid;
    logic [2:0]    center_x;
    logic [2:0]    center_y;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    logic [NB-1:0] mem [0:N-1];

    // reference model state
    bit m_active   = 1'b0;
    int m_issued   = 0;
    int m_push_idx = -1;
    int m_cv_c     = -1;
    bit m_rst_chk  = 1'b1;
    int n_push, n_cv, n_done;

    line_feeder #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .N_BITS       (NB),
        .ADDR_BITS    (AB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hold        (hold),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .sr_d        (sr_d),
        .sr_en       (sr_en),
        .center_valid(center_valid),
        .center_x    (center_x),
        .center_y    (center_y),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // frame memory: one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NB-1:0] push_word(input int i);
        if (i < N) return mem[i];
        if (WRAP) return mem[i - N];
        return '0;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic do_cycle(input bit h, input bit s, input bit r);
        bit exp_issue, exp_rd, start_acc;
        int next_push, next_cv;
        @(negedge clk);
        hold  = h;
        start = s;
        reset = r;
        #1;
        exp_issue = m_active && (m_issued < T) && !h;
        exp_rd    = exp_issue && ((m_issued < N) || WRAP);
        chk("mem_rd", {31'd0, mem_rd}, {31'd0, exp_rd});
        if (exp_rd)
            chk("mem_addr", {26'd0, mem_addr}, (m_issued < N) ? m_issued : m_issued - N);
        chk("sr_en", {31'd0, sr_en}, {31'd0, (m_push_idx < 0)});
        if (m_push_idx >= 0)
            chk("sr_d", {17'd0, sr_d}, {17'd0, push_word(m_push_idx)});
        chk("center_valid", {31'd0, center_valid}, {31'd0, (m_cv_c >= 0)});
        if (m_cv_c >= 0) begin
            chk("center_x", {29'd0, center_x}, m_cv_c % W);
            chk("center_y", {29'd0, center_y}, m_cv_c / W);
        end
        chk("done", {31'd0, done}, {31'd0, (m_cv_c == N - 1)});
        chk("busy", {31'd0, busy}, {31'd0, m_active});
        if (m_rst_chk) begin
            chk("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
            chk("rst_sr_d", {17'd0, sr_d}, 32'd0);
            chk("rst_center_x", {29'd0, center_x}, 32'd0);
            chk("rst_center_y", {29'd0, center_y}, 32'd0);
        end
        n_push += (sr_en === 1'b0) ? 1 : 0;
        n_cv   += (center_valid === 1'b1) ? 1 : 0;
        n_done += (done === 1'b1) ? 1 : 0;

        start_acc = s && !m_active;
        next_push = exp_issue ? m_issued : -1;
        next_cv   = ((m_push_idx >= 0) && (m_push_idx + 1 >= 2 * W)) ? m_push_idx + 1 - 2 * W : -1;
        if (exp_issue) m_issued++;
        if (m_cv_c == N - 1) m_active = 1'b0;
        if (start_acc) begin
            m_active = 1'b1;
            m_issued = 0;
        end
        m_push_idx = next_push;
        m_cv_c     = next_cv;
        m_rst_chk  = 1'b0;
        if (r) begin
            m_active   = 1'b0;
            m_issued   = 0;
            m_push_idx = -1;
            m_cv_c     = -1;
            m_rst_chk  = 1'b1;
        end
    endtask

    // mode 0: no hold; mode 1: 5-cycle hold mid-STREAM plus starts while busy;
    // mode 2: random hold and random spurious starts. rst_at < 0 means no reset.
    task automatic run_pass(input int mode, input int rst_at);
        bit h, s;
        n_push = 0;
        n_cv   = 0;
        n_done = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            h = 1'b0;
            s = (cyc == 0);
            if (mode == 1) begin
                h = (cyc >= 25) && (cyc < 30);
                s = s || (cyc == 10) || (cyc == 40);
            end else if (mode == 2) begin
                h = ($urandom_range(0, 3) == 0);
                s = s || ($urandom_range(0, 15) == 0);
            end
            do_cycle(h, s, cyc == rst_at);
            if ((cyc > 0) && !m_active) break;
        end
        if (rst_at < 0) begin
            chk("pass_pushes", n_push, T);
            chk("pass_centers", n_cv, N);
            chk("pass_dones", n_done, 1);
        end
    endtask

    initial begin
        hold  = 1'b0;
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        do_cycle(1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);

        // identity frame, free-running pass
        for (int i = 0; i < N; i++) mem[i] = NB'(i);
        run_pass(0, -1);
        do_cycle(1'b0, 1'b0, 1'b0);

        // random frame, hold burst and ignored starts
        for (int i = 0; i < N; i++) mem[i] = NB'($urandom);
        run_pass(1, -1);
        do_cycle(1'b0, 1'b0, 1'b0);

        // random frame, random hold
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < N; i++) mem[i] = NB'($urandom);
            run_pass(2, -1);
            do_cycle(1'b0, 1'b0, 1'b0);
        end

        // reset in the middle of a pass, then a full pass
        for (int i = 0; i < N; i++) mem[i] = NB'($urandom);
        run_pass(0, 30);
        do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);
        run_pass(2, -1);
        do_cycle(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
